// File: rtl/alu_tr_pkg.sv
// Shared types and constants for the time-redundant ALU scheduler.
package alu_tr_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN1,
      ST_RUN2,
      ST_RUN3,
      ST_RESP
   } tr_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_tr_scheduler_if.sv
// Request, ALU and response signals of the scheduler; slave is the scheduler side.
interface alu_tr_scheduler_if import alu_tr_pkg::*; #(
   parameter  int NREQ  = 2,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDW   = id_width(NREQ)
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_op;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [2:0]            alu_ctrl;
   logic [WIDTH-1:0]      alu_result;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_fault;
   logic                  rsp_uncorr;

   modport master (
      output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result,
             rsp_fault, rsp_uncorr
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result,
             rsp_fault, rsp_uncorr
   );
endinterface

// File: rtl/alu_tr_scheduler_rr_arbiter.sv
// Round-robin arbiter; the search starts just after the last accepted requester.
module rr_arbiter import alu_tr_pkg::*; #(
   parameter  int NREQ = 2,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);
   logic [IDW-1:0] last_grant;
   int             idx;

   // Scan from farthest to nearest so the requester closest after last_grant is written last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if ((req & (NREQ'(1) << idx)) != '0) begin
            grant     = NREQ'(1) << idx;
            grant_idx = IDW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)          last_grant <= IDW'(NREQ - 1);
      else if (advance) last_grant <= grant_idx;
   end

endmodule

// File: rtl/alu_tr_scheduler.sv
// Shares one ALU between requesters; each op runs twice, a third time on mismatch, then 2-of-3 vote.
//   state   | meaning
//   IDLE    | arbitrate and accept one request
//   RUN1    | first execution, capture r1
//   RUN2    | second execution, compare with r1
//   RUN3    | tie-break execution and vote
//   RESP    | hold response until rsp_ready
module alu_tr_scheduler import alu_tr_pkg::*; #(
   parameter  int NREQ  = 2,
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int CNTW  = 16,
   localparam int IDW   = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   alu_tr_scheduler_if.slave bus,
   output logic [CNTW-1:0]   fault_cnt,
   output logic              busy
);
   tr_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, r1_q, r2_q, res_q;
   logic [2:0]       op_q;
   logic [IDW-1:0]   id_q;
   logic             fault_q, uncorr_q;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             accept;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [2:0]       sel_op;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a  = bus.req_a[i*WIDTH +: WIDTH];
            sel_b  = bus.req_b[i*WIDTH +: WIDTH];
            sel_op = bus.req_op[i*3 +: 3];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // req_ready is masked during reset so a reset cycle never looks like an accept.
   always_comb begin
      state_d       = state_q;
      bus.req_ready = '0;
      accept        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rst && (bus.req_valid != '0)) begin
               bus.req_ready = grant;
               accept        = 1'b1;
               state_d       = ST_RUN1;
            end
         end
         ST_RUN1: state_d = ST_RUN2;
         ST_RUN2: state_d = (bus.alu_result == r1_q) ? ST_RESP : ST_RUN3;
         ST_RUN3: state_d = ST_RESP;
         ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         id_q      <= '0;
         r1_q      <= '0;
         r2_q      <= '0;
         res_q     <= '0;
         fault_q   <= 1'b0;
         uncorr_q  <= 1'b0;
         fault_cnt <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q      <= sel_a;
                  b_q      <= sel_b;
                  op_q     <= sel_op;
                  id_q     <= grant_idx;
                  fault_q  <= 1'b0;
                  uncorr_q <= 1'b0;
               end
            end
            ST_RUN1: r1_q <= bus.alu_result;
            ST_RUN2: begin
               r2_q <= bus.alu_result;
               if (bus.alu_result == r1_q) begin
                  res_q <= r1_q;
               end else begin
                  fault_q <= 1'b1;
                  if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
               end
            end
            ST_RUN3: begin
               if (bus.alu_result == r1_q) begin
                  res_q <= r1_q;
               end else if (bus.alu_result == r2_q) begin
                  res_q <= r2_q;
               end else begin
                  res_q    <= bus.alu_result;
                  uncorr_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_ctrl   = op_q;
   assign bus.rsp_valid  = (state_q == ST_RESP);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_result = res_q;
   assign bus.rsp_fault  = fault_q;
   assign bus.rsp_uncorr = uncorr_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/alu_tr_scheduler.md
# alu_tr_scheduler

Shares one combinational ALU between NREQ requesters and sequences time-redundant execution on it: each accepted operation runs twice, and a third time only on mismatch, followed by a 2-of-3 vote. The block sits between the requesting pipeline stages and the ALU datapath. It replaces per-requester redundancy control with one round-robin-arbitrated controller. It reports fault and uncorrectable status per response and keeps a saturating fault counter.

## Interface
- NREQ, 2: number of requesters (≥2)
- WIDTH, 32: operand/result width
- CNTW, 16: fault counter width
- IDW, max(1,$clog2(NREQ)): requester id width (derived)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a, req_b  in  NREQ*WIDTH  flattened operands, requester i at [i*WIDTH +: WIDTH]
- req_op  in  NREQ*3  flattened ALUControl codes
- alu_a, alu_b  out  WIDTH  operands driven to ALU
- alu_ctrl  out  3  ALUControl driven to ALU
- alu_result  in  WIDTH  combinational ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of response
- rsp_result  out  WIDTH  voted result
- rsp_fault  out  1  run1≠run2 occurred
- rsp_uncorr  out  1  all three runs differ
- fault_cnt  out  CNTW  saturating count of faulted transactions
- busy  out  1  state≠IDLE

## Operation
- States: IDLE, RUN1, RUN2, RUN3, RESP.
- IDLE: if any req_valid, round-robin arbiter picks index g (search starts at last_grant+1, wraps); req_ready[g]=1 combinationally, others 0. Handshake latches a/b/op/id and moves to RUN1. No valid: stay, req_ready=0.
- RUN1: ALU driven from latched operands; r1←alu_result; →RUN2.
- RUN2: same operands; r2←alu_result; if alu_result==r1 →RESP (result r1, fault 0); else →RUN3, fault flag set, fault_cnt increments (saturates at 2^CNTW−1).
- RUN3: r3←alu_result. Vote: r3==r1 → r1; else r3==r2 → r2; else result r3, uncorr=1. →RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; on handshake →IDLE. No new accept in the RESP cycle.
- alu_a/alu_b/alu_ctrl hold latched values in all states (0 after reset until first accept).
- Requester rule: req_valid and payload stable until req_ready; the block never accepts a requester whose valid is low.
- last_grant updates only on accept.

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_fault 0, rsp_uncorr 0, fault_cnt 0, busy 0, alu_* 0, last_grant NREQ−1 (requester 0 wins first).
- Accept at edge k: r1 at k+1, r2 at k+2; no fault: rsp_valid high from k+2; fault: from k+3.
- Peak throughput, no fault, rsp_ready tied high: one response per 4 cycles.
- rst mid-transaction: transaction dropped, no response, counter cleared, arbiter pointer reset.
- Simultaneous valids: strict round-robin; a continuously requesting agent waits at most NREQ−1 transactions.
- fault_cnt at max stays at max; rsp_fault still reported.

## Structure
- Package alu_tr_pkg: state enum, ALU op constants (ADD=3'b010 etc.), default WIDTH.
- Sub-module rr_arbiter (NREQ; inputs req, advance; outputs grant one-hot, grant_idx; owns last_grant).
- Vote logic inline in the controller.

## Test plan
- Single req0 A=0xF5, B=0xAA, op=010, clean ALU → rsp_result 0x19F, id 0, fault 0, rsp_valid 2 cycles after accept, fault_cnt 0.
- Same, ALU model inverts result during RUN2 only → RUN3 entered, result 0x19F, fault 1, uncorr 0, fault_cnt 1.
- ALU returns distinct values in RUN1/2/3 (0x1,0x2,0x3) → result 0x3, fault 1, uncorr 1.
- Both requesters valid continuously, clean ALU → grants alternate 0,1,0,1; rsp_id matches; each req_ready one cycle.
- rsp_ready held low 5 cycles → rsp_* stable, req_ready 0, busy 1; release → IDLE next cycle.
- rst asserted in RUN2 → next cycle all outputs at reset values, no rsp_valid; CNTW=2 with 5 faulted ops → fault_cnt stops at 3.
